// File: rtl/sccb_config_ctrl.sv
// SCCB (OV7670-style) configuration sequencer: walks a synchronous register table and
// issues one 3-phase write per entry, with timed-delay entries and an end marker.
module sccb_config_ctrl #(
  parameter int unsigned CLK_DIV   = 250,
  parameter logic [7:0]  DEV_ADDR  = 8'h42,
  parameter int unsigned MS_CYCLES = 100000,
  parameter int unsigned GAP_QTRS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sioc,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, START, BITS, STOP, GAP, DELAY, FINISH
  } state_t;

  localparam int QW = $clog2(CLK_DIV) + 1;
  localparam logic [QW-1:0] Q_LAST  = QW'(CLK_DIV - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_QTRS - 1);

  state_t        state_reg, state_next;
  logic [QW-1:0] qcnt_reg, qcnt_next;
  logic [7:0]    qtr_reg, qtr_next;
  logic [3:0]    bitn_reg, bitn_next;
  logic [1:0]    phase_reg, phase_next;
  logic [23:0]   shift_reg, shift_next;
  logic [15:0]   entry_reg, entry_next;
  logic [31:0]   dcnt_reg, dcnt_next;
  logic [7:0]    rom_addr_reg, rom_addr_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          ack_err_reg, ack_err_next;
  logic          sioc_reg, sioc_next;
  logic          siod_oe_reg, siod_oe_next;
  logic          tick, advance;

  assign tick = (qcnt_reg == Q_LAST);

  always_comb begin
    state_next    = state_reg;
    qtr_next      = qtr_reg;
    bitn_next     = bitn_reg;
    phase_next    = phase_reg;
    shift_next    = shift_reg;
    entry_next    = entry_reg;
    dcnt_next     = dcnt_reg;
    rom_addr_next = rom_addr_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    ack_err_next  = ack_err_reg;
    advance       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          rom_addr_next = 8'd0;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          ack_err_next  = 1'b0;
          state_next    = FETCH;
        end
      end
      FETCH: begin
        // Table has one cycle of read latency; take the word on the second cycle.
        if (qcnt_reg == QW'(1)) begin
          entry_next = rom_data;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (entry_reg == 16'hFFFF) begin
          state_next = FINISH;
        end else if (entry_reg[15:8] == 8'hF0) begin
          dcnt_next  = 32'(entry_reg[7:0]) * MS_CYCLES;
          state_next = DELAY;
        end else begin
          shift_next = {DEV_ADDR, entry_reg};
          qtr_next   = 8'd0;
          bitn_next  = 4'd0;
          phase_next = 2'd0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          qtr_next = 8'd0;
          if (qtr_reg == 8'd1) state_next = BITS;
          else                 qtr_next   = 8'd1;
        end
      end
      BITS: begin
        if (tick) begin
          if (qtr_reg == 8'd2 && bitn_reg == 4'd8 && siod_in) ack_err_next = 1'b1;
          if (qtr_reg == 8'd3) begin
            qtr_next = 8'd0;
            if (bitn_reg == 4'd8) begin
              bitn_next = 4'd0;
              if (phase_reg == 2'd2) state_next = STOP;
              else                   phase_next = phase_reg + 2'd1;
            end else begin
              bitn_next  = bitn_reg + 4'd1;
              shift_next = {shift_reg[22:0], 1'b0};
            end
          end else begin
            qtr_next = qtr_reg + 8'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (qtr_reg == 8'd2) begin
            qtr_next   = 8'd0;
            state_next = GAP;
          end else begin
            qtr_next = qtr_reg + 8'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (qtr_reg == GAP_LAST) advance = 1'b1;
          else                     qtr_next = qtr_reg + 8'd1;
        end
      end
      DELAY: begin
        // Counts whole clock cycles, not quarters; a zero count falls straight through.
        if (dcnt_reg <= 32'd1) advance = 1'b1;
        else                   dcnt_next = dcnt_reg - 32'd1;
      end
      FINISH: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (rom_addr_reg == 8'hFF) begin
        state_next = FINISH;
      end else begin
        rom_addr_next = rom_addr_reg + 8'd1;
        state_next    = FETCH;
      end
    end

    // Bus pins are decoded from the next state so the registered pins line up with it.
    sioc_next    = 1'b1;
    siod_oe_next = 1'b0;
    case (state_next)
      START: begin
        sioc_next    = (qtr_next == 8'd0);
        siod_oe_next = 1'b1;
      end
      BITS: begin
        sioc_next    = qtr_next[1];
        siod_oe_next = (bitn_next != 4'd8) && !shift_next[23];
      end
      STOP: begin
        sioc_next    = (qtr_next != 8'd0);
        siod_oe_next = (qtr_next != 8'd2);
      end
      default: ;
    endcase
  end

  assign qcnt_next = (state_next != state_reg || tick) ? '0 : qcnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      qcnt_reg     <= '0;
      qtr_reg      <= 8'd0;
      bitn_reg     <= 4'd0;
      phase_reg    <= 2'd0;
      shift_reg    <= 24'd0;
      entry_reg    <= 16'd0;
      dcnt_reg     <= 32'd0;
      rom_addr_reg <= 8'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
      sioc_reg     <= 1'b1;
      siod_oe_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      qcnt_reg     <= qcnt_next;
      qtr_reg      <= qtr_next;
      bitn_reg     <= bitn_next;
      phase_reg    <= phase_next;
      shift_reg    <= shift_next;
      entry_reg    <= entry_next;
      dcnt_reg     <= dcnt_next;
      rom_addr_reg <= rom_addr_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      ack_err_reg  <= ack_err_next;
      sioc_reg     <= sioc_next;
      siod_oe_reg  <= siod_oe_next;
    end
  end

  assign rom_addr = rom_addr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign ack_err  = ack_err_reg;
  assign sioc     = sioc_reg;
  assign siod_oe  = siod_oe_reg;

endmodule

// File: tb/tb_sccb_config_ctrl.sv
// Directed bench for sccb_config_ctrl: registered table ROM, an SCCB bus monitor that
// reassembles each frame into bytes, and one task per scenario.
`timescale 1ns/1ps
module tb_sccb_config_ctrl;
  localparam int CLK_DIV   = 4;
  localparam int MS_CYCLES = 10;
  localparam int GAP_QTRS  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc, siod_oe, siod_in;
  logic        busy, done, ack_err;
  logic        nack_mode = 1'b0;
  logic [15:0] rom [256];

  int n_checks = 0;
  int n_errors = 0;

  logic       prev_sioc = 1'b1, prev_oe = 1'b0, in_frame = 1'b0;
  logic [31:0] frame_bits = '0;
  int         frame_rises = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] q_bytes[$];
  int         q_bits[$];
  time        t_oe_rise = 0, t_release = 0, t_start = 0;

  always #5 clk = ~clk;

  // Released line reads high only when the slave is told to NACK; otherwise it acks (low).
  assign siod_in = nack_mode ? ~siod_oe : 1'b0;

  always @(posedge clk) rom_data <= rom[rom_addr];

  sccb_config_ctrl #(
    .CLK_DIV(CLK_DIV), .DEV_ADDR(8'h42), .MS_CYCLES(MS_CYCLES), .GAP_QTRS(GAP_QTRS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sioc(sioc), .siod_oe(siod_oe), .siod_in(siod_in), .busy(busy), .done(done),
    .ack_err(ack_err)
  );

  // Bus monitor: start = SIOD falls with SIOC high, stop = SIOD rises with SIOC high.
  // A frame holds 27 data clocks plus the clock that precedes the stop condition.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sioc && prev_sioc && siod_oe && !prev_oe) begin
          start_cnt++;
          in_frame    = 1'b1;
          frame_bits  = '0;
          frame_rises = 0;
          t_oe_rise   = $time;
        end else if (sioc && prev_sioc && !siod_oe && prev_oe && in_frame) begin
          stop_cnt++;
          in_frame  = 1'b0;
          t_release = $time;
          q_bytes.push_back(frame_bits[27:20]);
          q_bytes.push_back(frame_bits[18:11]);
          q_bytes.push_back(frame_bits[9:2]);
          q_bits.push_back(frame_rises - 1);
          $display("txn %0d: bytes %h %h %h, %0d data clocks", stop_cnt,
                   frame_bits[27:20], frame_bits[18:11], frame_bits[9:2], frame_rises - 1);
        end
        if (sioc && !prev_sioc && in_frame) begin
          frame_bits = {frame_bits[30:0], ~siod_oe};
          frame_rises++;
        end
      end
      prev_sioc = sioc;
      prev_oe   = siod_oe;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_frame && frame_rises >= n && !sioc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic get_frame(output logic [23:0] bytes, output int nbytes, output int nbits);
    nbytes = q_bytes.size();
    bytes  = 'x;
    nbits  = -1;
    if (nbytes >= 3) bytes = {q_bytes[0], q_bytes[1], q_bytes[2]};
    if (q_bits.size() > 0) nbits = q_bits[0];
  endtask

  task automatic load_write_table(input logic [15:0] entry0);
    foreach (rom[i]) rom[i] = 16'hFFFF;
    rom[0] = entry0;
    q_bytes.delete();
    q_bits.delete();
  endtask

  task automatic test_reset();
    foreach (rom[i]) rom[i] = 16'hFFFF;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (sioc !== 1'b1) begin n_errors++; $display("FAIL reset_sioc: got %b required 1", sioc); end
    n_checks++; if (siod_oe !== 1'b0) begin n_errors++; $display("FAIL reset_siod_oe: got %b required 0", siod_oe); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (ack_err !== 1'b0) begin n_errors++; $display("FAIL reset_ack_err: got %b required 0", ack_err); end
    n_checks++; if (rom_addr !== 8'd0) begin n_errors++; $display("FAIL reset_rom_addr: got %h required 00", rom_addr); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    bit ok;
    int s0, p0, nb, nbits, dur;
    logic [23:0] bytes;
    load_write_table(16'h1280);
    s0 = start_cnt;
    p0 = stop_cnt;
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_set: got %b required 1", busy); end
    wait_done(2000, ok);
    get_frame(bytes, nb, nbits);
    // START 2 + BITS 108 + STOP 2 quarters until release, final STOP quarter after: 113 x 4 = 452.
    dur = int'((t_release - t_oe_rise) / 10);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL single_timeout: done=%b required 1", done); end
    n_checks++; if (nb != 3) begin n_errors++; $display("FAIL single_nbytes: got %0d required 3", nb); end
    n_checks++; if (bytes !== 24'h421280) begin n_errors++; $display("FAIL single_bytes: got %h required 421280", bytes); end
    n_checks++; if (nbits != 27) begin n_errors++; $display("FAIL single_clocks: got %0d required 27", nbits); end
    n_checks++; if (start_cnt - s0 != 1) begin n_errors++; $display("FAIL single_start_cond: got %0d required 1", start_cnt - s0); end
    n_checks++; if (stop_cnt - p0 != 1) begin n_errors++; $display("FAIL single_stop_cond: got %0d required 1", stop_cnt - p0); end
    n_checks++; if (dur != 448) begin n_errors++; $display("FAIL single_bus_cycles: got %0d required 448 (+4 final stop quarter)", dur); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end: got %b required 0", busy); end
    n_checks++; if (rom_addr !== 8'd1) begin n_errors++; $display("FAIL single_rom_addr: got %h required 01", rom_addr); end
    n_checks++; if (ack_err !== 1'b0) begin n_errors++; $display("FAIL single_ack_err: got %b required 0", ack_err); end
  endtask

  task automatic test_delay();
    bit ok;
    int nb, nbits, lat;
    logic [23:0] bytes;
    load_write_table(16'hF003);
    rom[1] = 16'h1111;
    pulse_start();
    wait_done(2000, ok);
    get_frame(bytes, nb, nbits);
    // FETCH 2 + DECODE 1 + DELAY 30 + FETCH 2 + DECODE 1 = 36 cycles to the start condition.
    lat = int'((t_oe_rise - 5 - t_start) / 10);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL delay_timeout: done=%b required 1", done); end
    n_checks++; if (lat < 33 || lat > 39) begin n_errors++; $display("FAIL delay_latency: got %0d cycles required 36+-3", lat); end
    n_checks++; if (bytes !== 24'h421111) begin n_errors++; $display("FAIL delay_bytes: got %h required 421111", bytes); end
    n_checks++; if (nb != 3) begin n_errors++; $display("FAIL delay_nbytes: got %0d required 3", nb); end
    n_checks++; if (rom_addr !== 8'd2) begin n_errors++; $display("FAIL delay_rom_addr: got %h required 02", rom_addr); end
  endtask

  task automatic test_ack();
    bit ok;
    int nb, nbits;
    logic [23:0] bytes;
    load_write_table(16'h1280);
    nack_mode = 1'b1;
    pulse_start();
    wait_done(2000, ok);
    get_frame(bytes, nb, nbits);
    nack_mode = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL nack_timeout: done=%b required 1", done); end
    n_checks++; if (ack_err !== 1'b1) begin n_errors++; $display("FAIL nack_ack_err: got %b required 1", ack_err); end
    n_checks++; if (bytes !== 24'h421280) begin n_errors++; $display("FAIL nack_bytes: got %h required 421280", bytes); end
    n_checks++; if (nbits != 27) begin n_errors++; $display("FAIL nack_clocks: got %0d required 27", nbits); end
    q_bytes.delete();
    q_bits.delete();
    pulse_start();
    n_checks++; if (ack_err !== 1'b0) begin n_errors++; $display("FAIL ack_clear_on_start: got %b required 0", ack_err); end
    wait_done(2000, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL ack_rerun_timeout: done=%b required 1", done); end
    n_checks++; if (ack_err !== 1'b0) begin n_errors++; $display("FAIL ack_rerun_ack_err: got %b required 0", ack_err); end
  endtask

  task automatic test_busy_ignore();
    bit ok, ok2;
    int s0, nb, nbits;
    logic [23:0] bytes;
    load_write_table(16'h1280);
    s0 = start_cnt;
    pulse_start();
    wait_rises(5, ok2);
    pulse_start();
    wait_done(2000, ok);
    get_frame(bytes, nb, nbits);
    n_checks++; if (ok2 !== 1'b1) begin n_errors++; $display("FAIL busy_midwrite_timeout: rises=%0d required 5", frame_rises); end
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL busy_timeout: done=%b required 1", done); end
    n_checks++; if (bytes !== 24'h421280) begin n_errors++; $display("FAIL busy_bytes: got %h required 421280", bytes); end
    repeat (40) @(negedge clk);
    n_checks++; if (start_cnt - s0 != 1) begin n_errors++; $display("FAIL busy_frames: got %0d required 1", start_cnt - s0); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_errors++; $display("FAIL busy_no_restart: busy=%b done=%b required 0 1", busy, done); end
  endtask

  task automatic test_overrun();
    bit ok, wrapped, seen_ff;
    int nb, nbits;
    logic [23:0] bytes;
    load_write_table(16'h1280);
    for (int i = 1; i < 256; i++) rom[i] = 16'hF000;
    pulse_start();
    ok = 1'b0;
    wrapped = 1'b0;
    seen_ff = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (seen_ff && rom_addr != 8'hFF) wrapped = 1'b1;
      if (rom_addr == 8'hFF) seen_ff = 1'b1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    get_frame(bytes, nb, nbits);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL overrun_timeout: done=%b required 1", done); end
    n_checks++; if (rom_addr !== 8'hFF) begin n_errors++; $display("FAIL overrun_rom_addr: got %h required ff", rom_addr); end
    n_checks++; if (wrapped !== 1'b0) begin n_errors++; $display("FAIL overrun_wrap: got %b required 0", wrapped); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL overrun_busy: got %b required 0", busy); end
    n_checks++; if (nb != 3 || bytes !== 24'h421280) begin n_errors++; $display("FAIL overrun_bytes: got %0d bytes %h required 3 421280", nb, bytes); end
  endtask

  task automatic test_mid_reset();
    bit ok, ok2;
    int nb, nbits;
    logic [23:0] bytes;
    load_write_table(16'h1280);
    pulse_start();
    wait_rises(12, ok2);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (ok2 !== 1'b1) begin n_errors++; $display("FAIL midrst_reach_phase2: rises=%0d required 12", frame_rises); end
    n_checks++; if (sioc !== 1'b1) begin n_errors++; $display("FAIL midrst_sioc: got %b required 1", sioc); end
    n_checks++; if (siod_oe !== 1'b0) begin n_errors++; $display("FAIL midrst_siod_oe: got %b required 0", siod_oe); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    q_bytes.delete();
    q_bits.delete();
    pulse_start();
    n_checks++; if (rom_addr !== 8'd0 || busy !== 1'b1) begin n_errors++; $display("FAIL midrst_restart: rom_addr=%h busy=%b required 00 1", rom_addr, busy); end
    wait_done(2000, ok);
    get_frame(bytes, nb, nbits);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL midrst_timeout: done=%b required 1", done); end
    n_checks++; if (bytes !== 24'h421280) begin n_errors++; $display("FAIL midrst_bytes: got %h required 421280", bytes); end
    n_checks++; if (rom_addr !== 8'd1) begin n_errors++; $display("FAIL midrst_rom_addr: got %h required 01", rom_addr); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_delay();
    test_ack();
    test_busy_ignore();
    test_overrun();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
